load_store_unit: RTL and testbench

//  MEM-stage data-memory engine for the RV64 5-stage pipeline. Consumes the EX/MEM register
//  (load/store flag, func3, address=ALU result, store data) and runs a req/ack handshake to data

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared encodings and lane helpers for the MEM-stage load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [6:0] c_opc_load  = 7'b0000011;
    localparam logic [6:0] c_opc_store = 7'b0100011;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_d  = 3'b011;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;
    localparam logic [2:0] c_f3_wu = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Address bits that must be zero for a naturally aligned access; 111 behaves as d.
    function automatic logic [2:0] align_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] size_strb(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_strb = 8'h01;
            2'b01:   size_strb = 8'h03;
            2'b10:   size_strb = 8'h0F;
            default: size_strb = 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Byte-lane steering: strobes and shifted store data, extended load data.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [2:0]  lane,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata_ext
);

    logic [63:0] w_rdata_sh;

    assign wstrb      = size_strb(func3) << lane;
    assign wdata_sh   = wdata << {lane, 3'b000};
    assign w_rdata_sh = rdata >> {lane, 3'b000};

    always_comb begin
        rdata_ext = w_rdata_sh;
        case (func3)
            c_f3_b:  rdata_ext = {{56{w_rdata_sh[7]}},  w_rdata_sh[7:0]};
            c_f3_h:  rdata_ext = {{48{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
            c_f3_w:  rdata_ext = {{32{w_rdata_sh[31]}}, w_rdata_sh[31:0]};
            c_f3_bu: rdata_ext = {56'd0, w_rdata_sh[7:0]};
            c_f3_hu: rdata_ext = {48'd0, w_rdata_sh[15:0]};
            c_f3_wu: rdata_ext = {32'd0, w_rdata_sh[31:0]};
            default: rdata_ext = w_rdata_sh;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage req/ack data-memory engine with pipeline stall and timeout.
//            LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [2:0]        req_func3,
    input  logic [63:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              bus_err
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

    lsu_state_e         r_state, w_state_nxt;
    logic               r_is_load, r_is_store;
    logic [2:0]         r_func3;
    logic [ADDR_W-1:0]  r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [4:0]         r_rd;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_wb_data;
    logic               r_bus_err;

    logic               w_accept, w_timeout;
    logic [2:0]         w_lowmask;
    logic [ADDR_W-1:0]  w_addr_in;
    logic [7:0]         w_strb;
    logic [XLEN-1:0]    w_wdata_sh, w_rdata_ext;

    assign w_lowmask = align_mask(req_func3);
    assign w_accept  = (r_state == IDLE) && req_valid && (req_is_load || req_is_store);
    assign w_timeout = (r_cnt == c_cnt_last);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misal, r_misalign;
    assign w_misal   = |(req_addr[2:0] & w_lowmask);
    assign w_addr_in = req_addr[ADDR_W-1:0];
    assign misalign  = r_misalign;
`else
    // Size-alignment keeps every access inside one doubleword.
    assign w_addr_in = {req_addr[ADDR_W-1:3], req_addr[2:0] & ~w_lowmask};
`endif

    lsu_lane_align u_lane_align (
        .func3     (r_func3),
        .lane      (r_addr[2:0]),
        .wdata     (r_wdata),
        .rdata     (mem_rdata),
        .wstrb     (w_strb),
        .wdata_sh  (w_wdata_sh),
        .rdata_ext (w_rdata_ext)
    );

    assign mem_addr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign mem_wdata = w_wdata_sh;
    assign wb_rd     = r_rd;
    assign wb_data   = r_wb_data;
    assign bus_err   = r_bus_err;

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_wstrb   = 8'h00;
        stall       = 1'b0;
        wb_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                stall = w_accept && !rst;
                if (w_accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    w_state_nxt = w_misal ? DONE : BUSY;
`else
                    w_state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                mem_req   = 1'b1;
                mem_we    = r_is_store;
                mem_wstrb = w_strb;
                stall     = !rst;
                if (mem_ack || w_timeout) w_state_nxt = DONE;
            end
            DONE: begin
`ifdef LSU_MISALIGN_TRAP_EN
                wb_valid = r_is_load && !r_misalign;
`else
                wb_valid = r_is_load;
`endif
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_func3    <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= 5'd0;
            r_cnt      <= '0;
            r_wb_data  <= '0;
            r_bus_err  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign <= w_accept && w_misal;
`endif
            if (w_accept) begin
                r_is_load  <= req_is_load;
                r_is_store <= req_is_store && !req_is_load;
                r_func3    <= req_func3;
                r_addr     <= w_addr_in;
                r_wdata    <= req_wdata;
                r_rd       <= req_rd;
                r_cnt      <= '0;
            end
            // An ack in the final timeout cycle still completes normally.
            if (r_state == BUSY) begin
                if (mem_ack) begin
                    if (r_is_load) r_wb_data <= w_rdata_ext;
                end else if (w_timeout) begin
                    r_bus_err <= 1'b1;
                    r_wb_data <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed and random accesses checked against a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int C_TO = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_is_load, req_is_store;
    logic [2:0]  req_func3;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    // scratch for the random phase
    bit          s_ld;
    logic [2:0]  s_f3;
    logic [63:0] s_addr, s_wd, s_rd;
    int          s_k, s_stalls, s_sz;

    load_store_unit #(.ADDR_W(32), .XLEN(64), .TIMEOUT_CYC(C_TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_is_load  (req_is_load),
        .req_is_store (req_is_store),
        .req_func3    (req_func3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign     (misalign),
`endif
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sz_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    // Reference load: pick sz bytes starting at byte lane, then extend.
    function automatic logic [63:0] ld_model(input logic [2:0] f3, input logic [63:0] raw, input int lane);
        logic [63:0] v, m;
        int sz;
        sz = sz_bytes(f3);
        v  = raw >> (8 * lane);
        if (sz < 8) begin
            m = (64'd1 << (8 * sz)) - 64'd1;
            v = v & m;
            if (f3 < 3'd4 && v[8 * sz - 1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic do_access(input bit ld, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [63:0] raw, input logic [4:0] rd,
                             input int k, output int stalls);
        int          sz, lane, strb;
        logic [63:0] ea, exp_ld;
        bit          ended;
        sz     = sz_bytes(f3);
        ea     = addr - (addr % 64'(sz));
        lane   = int'(ea % 64'd8);
        strb   = ((1 << sz) - 1) << lane;
        exp_ld = ld_model(f3, raw, lane);
        stalls = 0;
        ended  = 1'b0;

        tick();
        req_valid = 1'b1; req_is_load = ld; req_is_store = !ld;
        req_func3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd; mem_ack = 1'b0;
        #2;
        chk("accept_stall", 64'(stall), 64'd1);
        chk("accept_noreq", 64'(mem_req), 64'd0);
        if (stall) stalls++;

        for (int c = 1; c <= C_TO + 8 && !ended; c++) begin
            tick();
            mem_ack   = (k != 0 && c == k);
            mem_rdata = raw;
            #2;
            if (stall) stalls++;
            chk("busy_req", 64'(mem_req), 64'd1);
            if (c == 1) begin
                chk("busy_addr", 64'(mem_addr), 64'(ea[31:0] & 32'hFFFF_FFF8));
                chk("busy_strb", 64'(mem_wstrb), 64'(strb[7:0]));
                chk("busy_we",   64'(mem_we), 64'(!ld));
                if (!ld) chk("busy_wdata", mem_wdata, wd << (8 * lane));
            end
            if (mem_ack || c == C_TO) ended = 1'b1;
        end

        tick();
        mem_ack = 1'b0;
        #2;
        chk("done_stall", 64'(stall), 64'd0);
        chk("done_req",   64'(mem_req), 64'd0);
        chk("done_wbv",   64'(wb_valid), 64'(ld));
        chk("done_err",   64'(bus_err), 64'(k == 0));
`ifdef LSU_MISALIGN_TRAP_EN
        chk("done_mis",   64'(misalign), 64'd0);
`endif
        if (ld) begin
            chk("done_rd",   64'(wb_rd), 64'(rd));
            chk("done_data", wb_data, (k == 0) ? 64'd0 : exp_ld);
        end

        tick();
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        #2;
        chk("idle_wbv",   64'(wb_valid), 64'd0);
        chk("idle_err",   64'(bus_err), 64'd0);
        chk("idle_stall", 64'(stall), 64'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_func3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 64'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req",   64'(mem_req), 64'd0);
        chk("rst_we",    64'(mem_we), 64'd0);
        chk("rst_strb",  64'(mem_wstrb), 64'd0);
        chk("rst_wbv",   64'(wb_valid), 64'd0);
        chk("rst_err",   64'(bus_err), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_data",  wb_data, 64'd0);
        chk("rst_rd",    64'(wb_rd), 64'd0);
        chk("rst_addr",  64'(mem_addr), 64'd0);
        tick();
        rst = 1'b0;

        // sb 0xAB at 0x1005, ack in the second BUSY cycle
        do_access(1'b0, 3'b000, 64'h1005, 64'hAB, 64'd0, 5'd0, 2, s_stalls);
        chk("sb_stall_cycles", 64'(s_stalls), 64'd3);

        do_access(1'b1, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 5'd5, 1, s_stalls);
        chk("lb_lit", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        do_access(1'b1, 3'b100, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 5'd6, 3, s_stalls);
        chk("lbu_lit", wb_data, 64'h80);
        do_access(1'b1, 3'b010, 64'h1004, 64'd0, 64'hDEAD_BEEF_0000_0000, 5'd7, 1, s_stalls);
        chk("lw_lit", wb_data, 64'hFFFF_FFFF_DEAD_BEEF);
        do_access(1'b1, 3'b110, 64'h1004, 64'd0, 64'hDEAD_BEEF_0000_0000, 5'd8, 2, s_stalls);
        chk("lwu_lit", wb_data, 64'h0000_0000_DEAD_BEEF);

        // ld with no ack: timeout; then ack exactly on the last allowed cycle
        do_access(1'b1, 3'b011, 64'h3000, 64'd0, 64'h1234_5678_9ABC_DEF0, 5'd9, 0, s_stalls);
        do_access(1'b1, 3'b011, 64'h3008, 64'd0, 64'h0FED_CBA9_8765_4321, 5'd10, C_TO, s_stalls);

        // stray ack while idle is ignored
        tick();
        mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #2;
        chk("stray_req",   64'(mem_req), 64'd0);
        chk("stray_stall", 64'(stall), 64'd0);
        tick();
        mem_ack = 1'b0;
        #2;
        chk("stray_wbv", 64'(wb_valid), 64'd0);

        // reset in the second BUSY cycle, followed by a late ack
        tick();
        req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
        req_func3 = 3'b011; req_addr = 64'h2000; req_rd = 5'd3;
        #2;
        tick();
        #2;
        chk("rstbusy_req1", 64'(mem_req), 64'd1);
        tick();
        rst = 1'b1;
        #2;
        tick();
        rst = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; mem_ack = 1'b1;
        #2;
        chk("rstbusy_req",   64'(mem_req), 64'd0);
        chk("rstbusy_wbv",   64'(wb_valid), 64'd0);
        chk("rstbusy_stall", 64'(stall), 64'd0);
        tick();
        mem_ack = 1'b0;
        #2;
        chk("rstbusy_wbv2", 64'(wb_valid), 64'd0);
        chk("rstbusy_req2", 64'(mem_req), 64'd0);

        // lh at an odd address
`ifdef LSU_MISALIGN_TRAP_EN
        tick();
        req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
        req_func3 = 3'b001; req_addr = 64'h1001; req_rd = 5'd4;
        #2;
        chk("mis_accept_stall", 64'(stall), 64'd1);
        chk("mis_accept_req",   64'(mem_req), 64'd0);
        tick();
        #2;
        chk("mis_pulse", 64'(misalign), 64'd1);
        chk("mis_req",   64'(mem_req), 64'd0);
        chk("mis_wbv",   64'(wb_valid), 64'd0);
        chk("mis_stall", 64'(stall), 64'd0);
        tick();
        req_valid = 1'b0; req_is_load = 1'b0;
        #2;
        chk("mis_clear", 64'(misalign), 64'd0);
`else
        do_access(1'b1, 3'b001, 64'h1001, 64'd0, 64'h0000_0000_0000_C3A5, 5'd4, 1, s_stalls);
        chk("lh_forced", wb_data, 64'hFFFF_FFFF_FFFF_C3A5);
`endif

        for (int n = 0; n < 24; n++) begin
            s_ld   = 1'($urandom_range(0, 1));
            s_f3   = s_ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            s_addr = 64'h1000 + 64'($urandom_range(0, 4095));
            s_sz   = sz_bytes(s_f3);
`ifdef LSU_MISALIGN_TRAP_EN
            s_addr = s_addr - (s_addr % 64'(s_sz));
`endif
            s_wd   = {$urandom(), $urandom()};
            s_rd   = {$urandom(), $urandom()};
            s_k    = $urandom_range(1, 4);
            do_access(s_ld, s_f3, s_addr, s_wd, s_rd, 5'($urandom_range(1, 31)), s_k, s_stalls);
            chk("rand_stall_cycles", 64'(s_stalls), 64'(s_k + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
